// File: rtl/izh_pkg.sv
// Shared types, fixed-point constants and saturating arithmetic for the Izhikevich array.
// Arithmetic is carried in 64-bit signed intermediates and clamped to the requested word width.
package izh_pkg;

   typedef logic signed [63:0] wide_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT_W,
      ST_READ,
      ST_UPDATE,
      ST_EMIT,
      ST_FIN
   } state_t;

   localparam logic [1:0] SEL_A = 2'd0;
   localparam logic [1:0] SEL_B = 2'd1;
   localparam logic [1:0] SEL_C = 2'd2;
   localparam logic [1:0] SEL_D = 2'd3;

   function automatic wide_t k_0p04(input int f);
      return (wide_t'(4) <<< f) / wide_t'(100);
   endfunction

   function automatic wide_t k_int(input int whole, input int f);
      return wide_t'(whole) <<< f;
   endfunction

   function automatic wide_t sat_w(input wide_t x, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic wide_t sat_add(input wide_t x, input wide_t y, input int w);
      return sat_w(x + y, w);
   endfunction

   // Operands are already within w bits, so the 64-bit product cannot overflow.
   function automatic wide_t fx_mul_sat(input wide_t x, input wide_t y, input int w, input int f);
      wide_t p;
      p = x * y;
      return sat_w(p >>> f, w);
   endfunction

endpackage

// File: rtl/izh_neuron_array_datapath.sv
// Combinational Euler step of one Izhikevich neuron; every product and sum saturates.
module izh_datapath
   import izh_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 16,
   parameter int DT_SHIFT = 0
) (
   input  logic signed [DATA_W-1:0] v,
   input  logic signed [DATA_W-1:0] u,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic signed [DATA_W-1:0] i,
   output logic signed [DATA_W-1:0] vn,
   output logic signed [DATA_W-1:0] un,
   output logic                     spike
);

   localparam wide_t K004 = k_0p04(FRAC_W);
   localparam wide_t K5   = k_int(5, FRAC_W);
   localparam wide_t K140 = k_int(140, FRAC_W);
   localparam wide_t K30  = k_int(30, FRAC_W);

   wide_t vw, uw, aw, bw, iw;
   wide_t vsq, t1, t2, s1, s2, s3, dv;
   wide_t bv, du_in, du;
   wide_t vn_w, un_w;

   assign vw = 64'(v);
   assign uw = 64'(u);
   assign aw = 64'(a);
   assign bw = 64'(b);
   assign iw = 64'(i);

   assign vsq = fx_mul_sat(vw, vw, DATA_W, FRAC_W);
   assign t1  = fx_mul_sat(K004, vsq, DATA_W, FRAC_W);
   assign t2  = fx_mul_sat(K5, vw, DATA_W, FRAC_W);
   assign s1  = sat_add(t1, t2, DATA_W);
   assign s2  = sat_add(s1, K140, DATA_W);
   assign s3  = sat_add(s2, -uw, DATA_W);
   assign dv  = sat_add(s3, iw, DATA_W);

   assign bv    = fx_mul_sat(bw, vw, DATA_W, FRAC_W);
   assign du_in = sat_add(bv, -uw, DATA_W);
   assign du    = fx_mul_sat(aw, du_in, DATA_W, FRAC_W);

   assign vn_w = sat_add(vw, dv >>> DT_SHIFT, DATA_W);
   assign un_w = sat_add(uw, du >>> DT_SHIFT, DATA_W);

   assign vn    = DATA_W'(vn_w);
   assign un    = DATA_W'(un_w);
   assign spike = (vn_w >= K30);

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: one shared datapath, READ/UPDATE per neuron per step.
// Spikes leave as indices on a valid/ready stream; EMIT holds until the consumer accepts.
module izh_neuron_array
   import izh_pkg::*;
#(
   parameter int NUM_NEURONS = 8,
   parameter int DATA_W      = 32,
   parameter int FRAC_W      = 16,
   parameter int DT_SHIFT    = 0,
   parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              CFG_WE,
   input  logic [IDX_W-1:0]  CFG_ADDR,
   input  logic [1:0]        CFG_SEL,
   input  logic [DATA_W-1:0] CFG_DATA,
   input  logic              I_WE,
   input  logic [IDX_W-1:0]  I_ADDR,
   input  logic [DATA_W-1:0] I_DATA,
   input  logic              INIT,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic              SPIKE_VALID,
   output logic [IDX_W-1:0]  SPIKE_ID,
   input  logic              SPIKE_READY
);

   logic signed [DATA_W-1:0] v_mem [NUM_NEURONS];
   logic signed [DATA_W-1:0] u_mem [NUM_NEURONS];
   logic signed [DATA_W-1:0] a_mem [NUM_NEURONS];
   logic signed [DATA_W-1:0] b_mem [NUM_NEURONS];
   logic signed [DATA_W-1:0] c_mem [NUM_NEURONS];
   logic signed [DATA_W-1:0] d_mem [NUM_NEURONS];
   logic signed [DATA_W-1:0] ibuf  [NUM_NEURONS];

   logic signed [DATA_W-1:0] op_v, op_u, op_a, op_b, op_c, op_d, op_i;
   logic signed [DATA_W-1:0] dp_vn, dp_un, u_spk, ibuf_sum;
   logic                     dp_spike;
   wide_t                    u_spk_w, ibuf_sum_w;

   state_t           state, state_nx;
   logic [IDX_W-1:0] k;
   logic             last;

   assign last = (k == IDX_W'(NUM_NEURONS - 1));

   izh_datapath #(
      .DATA_W   (DATA_W),
      .FRAC_W   (FRAC_W),
      .DT_SHIFT (DT_SHIFT)
   ) u_dp (
      .v     (op_v),
      .u     (op_u),
      .a     (op_a),
      .b     (op_b),
      .i     (op_i),
      .vn    (dp_vn),
      .un    (dp_un),
      .spike (dp_spike)
   );

   assign u_spk_w    = sat_add(64'(dp_un), 64'(op_d), DATA_W);
   assign u_spk      = DATA_W'(u_spk_w);
   assign ibuf_sum_w = sat_add(64'(ibuf[I_ADDR]), 64'($signed(I_DATA)), DATA_W);
   assign ibuf_sum   = DATA_W'(ibuf_sum_w);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (INIT) state_nx = ST_INIT_W;
                    else if (START) state_nx = ST_READ;
         ST_INIT_W: if (last) state_nx = ST_FIN;
         ST_READ:   state_nx = ST_UPDATE;
         ST_UPDATE: if (dp_spike) state_nx = ST_EMIT;
                    else state_nx = last ? ST_FIN : ST_READ;
         ST_EMIT:   if (SPIKE_READY) state_nx = last ? ST_FIN : ST_READ;
         ST_FIN:    state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      BUSY        = (state != ST_IDLE);
      DONE        = (state == ST_FIN);
      SPIKE_VALID = (state == ST_EMIT);
      SPIKE_ID    = SPIKE_VALID ? k : '0;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         k <= '0;
      end else begin
         case (state)
            ST_IDLE:   k <= '0;
            ST_INIT_W: if (!last) k <= k + IDX_W'(1);
            ST_UPDATE: if (!dp_spike && !last) k <= k + IDX_W'(1);
            ST_EMIT:   if (SPIKE_READY && !last) k <= k + IDX_W'(1);
            default:   ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int j = 0; j < NUM_NEURONS; j++) begin
            v_mem[j] <= '0;
            u_mem[j] <= '0;
            a_mem[j] <= '0;
            b_mem[j] <= '0;
            c_mem[j] <= '0;
            d_mem[j] <= '0;
         end
         op_v <= '0; op_u <= '0; op_a <= '0; op_b <= '0;
         op_c <= '0; op_d <= '0; op_i <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (CFG_WE) begin
                  case (CFG_SEL)
                     SEL_A:   a_mem[CFG_ADDR] <= CFG_DATA;
                     SEL_B:   b_mem[CFG_ADDR] <= CFG_DATA;
                     SEL_C:   c_mem[CFG_ADDR] <= CFG_DATA;
                     default: d_mem[CFG_ADDR] <= CFG_DATA;
                  endcase
               end
            end
            ST_INIT_W: begin
               v_mem[k] <= c_mem[k];
               u_mem[k] <= b_mem[k];
            end
            ST_READ: begin
               op_v <= v_mem[k];
               op_u <= u_mem[k];
               op_a <= a_mem[k];
               op_b <= b_mem[k];
               op_c <= c_mem[k];
               op_d <= d_mem[k];
               op_i <= ibuf[k];
            end
            ST_UPDATE: begin
               v_mem[k] <= dp_spike ? op_c : dp_vn;
               u_mem[k] <= dp_spike ? u_spk : dp_un;
            end
            default: ;
         endcase
      end
   end

   // A write colliding with the UPDATE clear replaces the entry, so it counts toward the next step.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int j = 0; j < NUM_NEURONS; j++) ibuf[j] <= '0;
      end else begin
         for (int j = 0; j < NUM_NEURONS; j++) begin
            if (state == ST_UPDATE && k == IDX_W'(j))
               ibuf[j] <= (I_WE && I_ADDR == IDX_W'(j)) ? I_DATA : '0;
            else if (I_WE && I_ADDR == IDX_W'(j))
               ibuf[j] <= ibuf_sum;
         end
      end
   end

endmodule
